// File: rtl/alu_mem_serdes_pkg.sv
// alu_mem_serdes shared types: FSM state encoding and symbol-count helper.
// Imported by the shift-register sub-module and the top.
package alu_mem_serdes_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LD_LO = 3'd1,
    S_LD_HI = 3'd2,
    S_RUN   = 3'd3,
    S_ST_LO = 3'd4,
    S_ST_HI = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  localparam int REG_BITS_DEF = 8;
  localparam int NSHIFT_DEF   = 2;

  function automatic int syms_per_byte(input int rb, input int ns);
    return rb / ns;
  endfunction

endpackage

// File: rtl/alu_mem_serdes_shreg.sv
// 2*REG_BITS operand/result shift register: byte loads, hold, and
// serial insertion at bit 2*REG_BITS-1 (pair) or REG_BITS-1 (single).
module alu_mem_serdes_shreg
  import alu_mem_serdes_pkg::*;
#(
  parameter int REG_BITS = REG_BITS_DEF,
  parameter int NSHIFT   = NSHIFT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_lo_i,
  input  logic                  ld_hi_i,
  input  logic                  shift_i,
  input  logic                  pair_i,
  input  logic [REG_BITS-1:0]   byte_i,
  input  logic [NSHIFT-1:0]     sin_i,
  output logic [2*REG_BITS-1:0] q_o
);

  localparam int W = 2 * REG_BITS;

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    unique case (1'b1)
      ld_lo_i: q_d[REG_BITS-1:0] = byte_i;
      ld_hi_i: q_d[W-1:REG_BITS] = byte_i;
      shift_i && pair_i:
        q_d = {sin_i, q_q[W-1:NSHIFT]};
      shift_i && !pair_i:
        q_d[REG_BITS-1:0] =
          {sin_i, q_q[REG_BITS-1:NSHIFT]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/alu_mem_serdes.sv
// Memory operand stage for the bit-serial ALU: byte-wide fetch,
// NSHIFT-bit streaming in/out of one shift register, optional write-back.
module alu_mem_serdes
  import alu_mem_serdes_pkg::*;
#(
  parameter int REG_BITS = REG_BITS_DEF,
  parameter int NSHIFT   = NSHIFT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                need_load,
  input  logic                need_store,
  input  logic                pair,
  output logic                busy,
  output logic                done,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_hi,
  output logic [REG_BITS-1:0] mem_wdata,
  input  logic [REG_BITS-1:0] mem_rdata,
  input  logic                mem_ack,
  output logic                alu_go,
  input  logic                alu_active,
  input  logic                alu_op_done,
  output logic [NSHIFT-1:0]   data_in,
  input  logic [NSHIFT-1:0]   data_out
);

  localparam int SYMS = syms_per_byte(REG_BITS, NSHIFT);
  localparam int CW   = $clog2(2 * SYMS);

  state_e state_q, state_d;
  logic   st_q, st_d;
  logic   pr_q, pr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic ld_lo, ld_hi, shift;
  logic [2*REG_BITS-1:0] sreg;

  alu_mem_serdes_shreg #(
    .REG_BITS(REG_BITS),
    .NSHIFT  (NSHIFT)
  ) u_shreg (
    .clk    (clk),
    .reset  (reset),
    .ld_lo_i(ld_lo),
    .ld_hi_i(ld_hi),
    .shift_i(shift),
    .pair_i (pr_q),
    .byte_i (mem_rdata),
    .sin_i  (data_out),
    .q_o    (sreg)
  );

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    pr_d    = pr_q;
    cnt_d   = cnt_q;
    ld_lo   = 1'b0;
    ld_hi   = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          st_d    = need_store;
          pr_d    = pair;
          cnt_d   = '0;
          state_d = need_load ? S_LD_LO : S_RUN;
        end
      end
      S_LD_LO: begin
        if (mem_ack) begin
          ld_lo   = 1'b1;
          state_d = pr_q ? S_LD_HI : S_RUN;
        end
      end
      S_LD_HI: begin
        if (mem_ack) begin
          ld_hi   = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // op_done only counts on a cycle the ALU actually moved a symbol
        if (alu_active) begin
          shift = 1'b1;
          cnt_d = cnt_q + CW'(1);
          if (alu_op_done)
            state_d = st_q ? S_ST_LO : S_DONE;
        end
      end
      S_ST_LO: begin
        if (mem_ack)
          state_d = pr_q ? S_ST_HI : S_DONE;
      end
      S_ST_HI: begin
        if (mem_ack) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      st_q    <= 1'b0;
      pr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      pr_q    <= pr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    alu_go    = (state_q == S_RUN);
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_hi    = 1'b0;
    mem_wdata = '0;
    unique case (state_q)
      S_LD_LO: mem_req = 1'b1;
      S_LD_HI: begin
        mem_req = 1'b1;
        mem_hi  = 1'b1;
      end
      S_ST_LO: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = sreg[REG_BITS-1:0];
      end
      S_ST_HI: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_hi    = 1'b1;
        mem_wdata = sreg[2*REG_BITS-1:REG_BITS];
      end
      default: ;
    endcase
  end

  assign data_in = sreg[NSHIFT-1:0];

endmodule

// File: tb/tb_alu_mem_serdes.sv
// Directed bench for alu_mem_serdes: byte memory model driven inline,
// ALU modelled as data_out = data_in + 1 (mod 4).
module tb_alu_mem_serdes;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, need_load, need_store, pair;
  logic       busy, done;
  logic       mem_req, mem_we, mem_hi;
  logic [7:0] mem_wdata, mem_rdata;
  logic       mem_ack;
  logic       alu_go, alu_active, alu_op_done;
  logic [1:0] data_in, data_out;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_memtx = 0;
  int n_done  = 0;

  always #5 clk = ~clk;

  assign data_out = data_in + 2'd1;

  alu_mem_serdes dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .need_load  (need_load),
    .need_store (need_store),
    .pair       (pair),
    .busy       (busy),
    .done       (done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_hi     (mem_hi),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .alu_go     (alu_go),
    .alu_active (alu_active),
    .alu_op_done(alu_op_done),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  always @(posedge clk) begin
    if (mem_req && mem_ack) n_memtx <= n_memtx + 1;
    if (done) n_done <= n_done + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_tx(input logic ld, input logic st, input logic pr);
    need_load  = ld;
    need_store = st;
    pair       = pr;
    start      = 1'b1;
    cyc        = 0;
    tick();
    start      = 1'b0;
  endtask

  task automatic mem_cycle(input string tag, input logic we,
                           input logic hi, input logic [7:0] wd,
                           input logic [7:0] rd, input int waits);
    chk({tag, "_req"}, int'(mem_req), 1);
    chk({tag, "_we"}, int'(mem_we), int'(we));
    chk({tag, "_hi"}, int'(mem_hi), int'(hi));
    if (we) chk({tag, "_wdata"}, int'(mem_wdata), int'(wd));
    for (int w = 0; w < waits; w++) begin
      mem_ack = 1'b0;
      tick();
      chk({tag, "_reqhold"}, int'(mem_req), 1);
      chk({tag, "_hihold"}, int'(mem_hi), int'(hi));
      if (we) chk({tag, "_wdhold"}, int'(mem_wdata), int'(wd));
    end
    mem_rdata = rd;
    mem_ack   = 1'b1;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
  endtask

  // Streams n active symbols; src gives the required data_in sequence.
  task automatic run_syms(input string tag, input int n,
                          input logic [15:0] src, input bit gaps);
    int k = 0;
    int j = 0;
    logic [15:0] s;
    while (k < n && j < 64) begin
      s = src >> (2 * k);
      chk({tag, "_go"}, int'(alu_go), 1);
      chk({tag, "_din"}, int'(data_in), int'(s[1:0]));
      alu_active  = gaps ? (j % 2 == 0) : 1'b1;
      // op_done on a gap cycle must be ignored
      alu_op_done = (k == n - 1);
      tick();
      if (alu_active) k++;
      j++;
    end
    alu_active  = 1'b0;
    alu_op_done = 1'b0;
    chk({tag, "_nsym"}, k, n);
  endtask

  initial begin
    int base_tx;
    int base_done;
    reset = 1'b1;
    start = 0; need_load = 0; need_store = 0; pair = 0;
    mem_rdata = 8'h00; mem_ack = 0;
    alu_active = 0; alu_op_done = 0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_req", int'(mem_req), 0);
    chk("rst_go", int'(alu_go), 0);
    chk("rst_din", int'(data_in), 0);
    chk("rst_sreg", int'(dut.sreg), 0);

    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_busy", int'(busy), 0);
    chk("idle_ack_req", int'(mem_req), 0);

    // pair load+store, zero wait
    start_tx(1, 1, 1);
    mem_cycle("t1_ldlo", 0, 0, 8'h00, 8'h34, 0);
    mem_cycle("t1_ldhi", 0, 1, 8'h00, 8'h12, 0);
    run_syms("t1_run", 8, 16'h1234, 0);
    mem_cycle("t1_stlo", 1, 0, 8'h49, 8'h00, 0);
    mem_cycle("t1_sthi", 1, 1, 8'h67, 8'h00, 0);
    chk("t1_done", int'(done), 1);
    chk("t1_lat", cyc, 13);
    tick();
    chk("t1_idle", int'(busy), 0);
    chk("t1_done_clr", int'(done), 0);

    // single byte, load only
    base_tx = n_memtx;
    start_tx(1, 0, 0);
    mem_cycle("t2_ldlo", 0, 0, 8'h00, 8'hA5, 0);
    run_syms("t2_run", 4, 16'h00A5, 0);
    chk("t2_done", int'(done), 1);
    chk("t2_lat", cyc, 6);
    chk("t2_sreg", int'(dut.sreg), 16'h67FA);
    chk("t2_ntx", n_memtx - base_tx, 1);
    tick();
    chk("t2_idle", int'(busy), 0);

    // wait states and alu_active gaps
    start_tx(1, 1, 1);
    mem_cycle("t3_ldlo", 0, 0, 8'h00, 8'h34, 3);
    mem_cycle("t3_ldhi", 0, 1, 8'h00, 8'h12, 3);
    run_syms("t3_run", 8, 16'h1234, 1);
    mem_cycle("t3_stlo", 1, 0, 8'h49, 8'h00, 3);
    mem_cycle("t3_sthi", 1, 1, 8'h67, 8'h00, 3);
    chk("t3_done", int'(done), 1);
    tick();

    // load-free chain on previous result 0x6749
    start_tx(0, 1, 1);
    chk("t6_noreq", int'(mem_req), 0);
    run_syms("t6_run", 8, 16'h6749, 0);
    mem_cycle("t6_stlo", 1, 0, 8'h9E, 8'h00, 0);
    mem_cycle("t6_sthi", 1, 1, 8'hB8, 8'h00, 0);
    chk("t6_done", int'(done), 1);
    tick();

    // reset in the middle of RUN
    start_tx(1, 1, 1);
    mem_cycle("t4_ldlo", 0, 0, 8'h00, 8'h34, 0);
    mem_cycle("t4_ldhi", 0, 1, 8'h00, 8'h12, 0);
    alu_active = 1'b1;
    repeat (3) tick();
    alu_active = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_busy", int'(busy), 0);
    chk("t4_req", int'(mem_req), 0);
    chk("t4_go", int'(alu_go), 0);
    chk("t4_sreg", int'(dut.sreg), 0);
    chk("t4_din", int'(data_in), 0);
    start_tx(1, 1, 0);
    mem_cycle("t4b_ldlo", 0, 0, 8'h00, 8'hA5, 0);
    run_syms("t4b_run", 4, 16'h00A5, 0);
    mem_cycle("t4b_stlo", 1, 0, 8'hFA, 8'h00, 0);
    chk("t4b_done", int'(done), 1);
    chk("t4b_sreg", int'(dut.sreg), 16'h00FA);
    tick();

    // start pulses in LD_HI, RUN, DONE are ignored
    base_done = n_done;
    start_tx(1, 0, 1);
    mem_cycle("t5_ldlo", 0, 0, 8'h00, 8'h34, 0);
    start = 1'b1;
    mem_cycle("t5_ldhi", 0, 1, 8'h00, 8'h12, 0);
    run_syms("t5_run", 8, 16'h1234, 0);
    chk("t5_done", int'(done), 1);
    tick();
    start = 1'b0;
    chk("t5_idle", int'(busy), 0);
    chk("t5_noreq", int'(mem_req), 0);
    tick();
    chk("t5_idle2", int'(busy), 0);
    chk("t5_sreg", int'(dut.sreg), 16'h6749);
    chk("t5_ndone", n_done - base_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
